// File: rtl/r8acc_pkg.sv
// Shared types and constants for the radix-8 Booth sequential accumulator
// and its digit selector.
package r8acc_pkg;

    localparam int unsigned DW   = 16;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned NDIG = (DW + 2 + 2) / 3;
    localparam int unsigned XW   = 3 * NDIG;
    localparam int unsigned CW   = $clog2(NDIG);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } booth_digit_t;

    // Window {x[3i+2], x[3i+1], x[3i], x[3i-1]} -> sign/magnitude digit in -4..+4
    function automatic booth_digit_t booth_decode(input logic [3:0] win);
        booth_digit_t d;
        logic [2:0]   s;
        s = {1'b0, win[2], 1'b0} + {2'b00, win[1]} + {2'b00, win[0]};
        if (win[3]) begin
            d.mag = 3'd4 - s;
            d.neg = (s != 3'd4);
        end else begin
            d.mag = s;
            d.neg = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/r8_booth_digit_sel.sv
// Combinational radix-8 Booth digit selector: picks the multiple for one
// 4-bit digit window and negates it for negative digits.
module r8_booth_digit_sel
    import r8acc_pkg::*;
(
    input  logic [3:0]    win,
    input  logic [PW-1:0] m0,
    input  logic [PW-1:0] m1,
    input  logic [PW-1:0] m2,
    input  logic [PW-1:0] m3,
    input  logic [PW-1:0] m4,
    output logic [PW-1:0] multiple_c
);

    booth_digit_t  dig;
    logic [PW-1:0] mag_m;

    always_comb begin
        dig = booth_decode(win);
        case (dig.mag)
            3'd0:    mag_m = m0;
            3'd1:    mag_m = m1;
            3'd2:    mag_m = m2;
            3'd3:    mag_m = m3;
            default: mag_m = m4;
        endcase
        multiple_c = dig.neg ? (~mag_m + PW'(1)) : mag_m;
    end

endmodule

// File: rtl/r8_booth_seq_acc.sv
// Iterative radix-8 Booth back end: one digit of B per cycle, accumulating
// the selected shifted multiple into a PW-bit product.
module r8_booth_seq_acc
    import r8acc_pkg::*;
#(
    parameter int unsigned APPROX_DIGITS = 0
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] b_in,
    input  logic [PW-1:0] prod0,
    input  logic [PW-1:0] prod1,
    input  logic [PW-1:0] prod2,
    input  logic [PW-1:0] prod3,
    input  logic [PW-1:0] prod4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] p_out
);

    localparam int unsigned     SW       = $clog2(XW);
    localparam int unsigned     DROP_INT = (32'd1 << APPROX_DIGITS) - 32'd1;
    localparam logic [NDIG-1:0] DROP     = NDIG'(DROP_INT);

    state_t        state_q, state_next;
    logic [PW-1:0] m0_q, m1_q, m2_q, m3_q, m4_q;
    logic [XW:0]   xs_q;
    logic [PW-1:0] acc_q;
    logic [CW-1:0] cnt_q;

    logic [PW-1:0] multiple_c;
    logic [PW-1:0] addend;
    logic [PW-1:0] acc_next;
    logic [SW-1:0] shamt;

    r8_booth_digit_sel u_sel (
        .win        (xs_q[3:0]),
        .m0         (m0_q),
        .m1         (m1_q),
        .m2         (m2_q),
        .m3         (m3_q),
        .m4         (m4_q),
        .multiple_c (multiple_c)
    );

    // Truncated low digits still take their cycle but add nothing
    always_comb begin
        shamt    = SW'(cnt_q) * SW'(3);
        addend   = DROP[cnt_q] ? '0 : (multiple_c << shamt);
        acc_next = acc_q + addend;
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt_q == CW'(NDIG - 1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            p_out     <= '0;
            m0_q      <= '0;
            m1_q      <= '0;
            m2_q      <= '0;
            m3_q      <= '0;
            m4_q      <= '0;
            xs_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
        end else begin
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        m0_q  <= prod0;
                        m1_q  <= prod1;
                        m2_q  <= prod2;
                        m3_q  <= prod3;
                        m4_q  <= prod4;
                        xs_q  <= {{(XW - DW){b_in[DW-1]}}, b_in, 1'b0};
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_next;
                    xs_q  <= {{3{xs_q[XW]}}, xs_q[XW:3]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NDIG - 1)) p_out <= acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_r8_booth_seq_acc.sv
// Scoreboard bench for r8_booth_seq_acc: directed operands with hand-computed
// products, an exact instance and a one-digit-truncated instance.
module tb_r8_booth_seq_acc;

    logic        clk;
    logic        rst_n;
    logic        iv, iv_a;
    logic        in_ready, in_ready_a;
    logic [15:0] b_in;
    logic [31:0] prod0, prod1, prod2, prod3, prod4;
    logic        out_valid, out_valid_a;
    logic        out_ready;
    logic [31:0] p_out, p_out_a;

    typedef struct {
        logic [31:0] p;
        int          e0;
    } exp_t;

    exp_t q[$];
    exp_t qa[$];
    int   cyc;
    int   vectors;
    int   miscompares;

    r8_booth_seq_acc #(.APPROX_DIGITS(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready),
        .b_in(b_in), .prod0(prod0), .prod1(prod1), .prod2(prod2),
        .prod3(prod3), .prod4(prod4), .out_valid(out_valid),
        .out_ready(out_ready), .p_out(p_out)
    );

    r8_booth_seq_acc #(.APPROX_DIGITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(in_ready_a),
        .b_in(b_in), .prod0(prod0), .prod1(prod1), .prod2(prod2),
        .prod3(prod3), .prod4(prod4), .out_valid(out_valid_a),
        .out_ready(1'b1), .p_out(p_out_a)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_a(input int a);
        prod0 = 32'd0;
        prod1 = 32'(a);
        prod2 = 32'(2 * a);
        prod3 = 32'(3 * a);
        prod4 = 32'(4 * a);
    endtask

    task automatic issue(input int a, input int b, input logic [31:0] expv, input bit push, input bit approx);
        bit   got;
        exp_t e;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = approx ? in_ready_a : in_ready;
        end
        if (!got) chk(0, "in_ready_timeout", 32'(0), 32'(1));
        set_a(a);
        b_in = 16'(b);
        if (approx) iv_a = 1'b1;
        else        iv   = 1'b1;
        e.p  = expv;
        e.e0 = cyc + 1;
        if (push) begin
            if (approx) qa.push_back(e);
            else        q.push_back(e);
        end
        @(posedge clk); #1;
        iv   = 1'b0;
        iv_a = 1'b0;
    endtask

    task automatic wait_valid();
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            got = out_valid;
        end
        if (!got) chk(0, "out_valid_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_drain();
        bit done;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk); #1;
            done = (q.size() == 0) && (qa.size() == 0);
        end
        if (!done) begin
            chk(0, "drain_timeout", 32'(q.size() + qa.size()), 32'(0));
            q.delete();
            qa.delete();
        end
    endtask

    // Monitor: compare every presented product against the scoreboard head
    initial begin
        bit prev;
        bit prev_a;
        prev   = 0;
        prev_a = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev   = 0;
                prev_a = 0;
            end else begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk(0, "unexpected_out", p_out, 32'(0));
                    end else begin
                        if (!prev) chk((cyc - q[0].e0) == 6, "latency", 32'(cyc - q[0].e0), 32'(6));
                        chk(p_out == q[0].p, "p_out", p_out, q[0].p);
                        if (out_ready) void'(q.pop_front());
                    end
                end
                if (out_valid_a) begin
                    if (qa.size() == 0) begin
                        chk(0, "unexpected_out_approx", p_out_a, 32'(0));
                    end else begin
                        if (!prev_a) chk((cyc - qa[0].e0) == 6, "latency_approx", 32'(cyc - qa[0].e0), 32'(6));
                        chk(p_out_a == qa[0].p, "p_out_approx", p_out_a, qa[0].p);
                        void'(qa.pop_front());
                    end
                end
                prev   = out_valid;
                prev_a = out_valid_a;
            end
        end
    end

    initial begin
        cyc         = 0;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        iv          = 1'b0;
        iv_a        = 1'b0;
        out_ready   = 1'b1;
        b_in        = '0;
        set_a(0);
        #23;
        chk(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'(1));
        chk(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'(0));
        chk(p_out == 32'd0, "reset_p_out", p_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic op plus handshake-to-ready timing
        issue(3, 5, 32'h0000_000F, 1, 0);
        wait_valid();
        chk(in_ready == 1'b0, "in_ready_in_done", 32'(in_ready), 32'(0));
        @(posedge clk); #1;
        chk(in_ready == 1'b1, "in_ready_after_hs", 32'(in_ready), 32'(1));
        chk(out_valid == 1'b0, "out_valid_after_hs", 32'(out_valid), 32'(0));

        issue(-7, 100, 32'hFFFF_FD44, 1, 0);
        wait_drain();
        issue(-32768, -32768, 32'h4000_0000, 1, 0);
        wait_drain();
        issue(-1, -1, 32'h0000_0001, 1, 0);
        wait_drain();
        issue(0, 12345, 32'h0000_0000, 1, 0);
        wait_drain();
        issue(-1, 32767, 32'hFFFF_8001, 1, 0);
        wait_drain();
        issue(256, 256, 32'h0001_0000, 1, 0);
        wait_drain();

        // Output stall with in_valid pulses that must be ignored
        out_ready = 1'b0;
        issue(32767, -32768, 32'hC000_8000, 1, 0);
        wait_valid();
        for (int i = 0; i < 3; i++) begin
            chk(in_ready == 1'b0, "in_ready_stall", 32'(in_ready), 32'(0));
            iv   = 1'b1;
            set_a(1);
            b_in = 16'd1;
            @(posedge clk); #1;
            chk(out_valid == 1'b1, "out_valid_stall", 32'(out_valid), 32'(1));
        end
        iv        = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Approximate instance drops digit 0
        issue(3, 5, 32'h0000_0018, 1, 1);
        wait_drain();

        // Asynchronous abort mid-RUN, then a fresh op
        issue(3, 5, 32'h0000_000F, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "abort_out_valid", 32'(out_valid), 32'(0));
        chk(p_out == 32'd0, "abort_p_out", p_out, 32'd0);
        chk(in_ready == 1'b1, "abort_in_ready", 32'(in_ready), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        issue(2, 2, 32'h0000_0004, 1, 0);
        wait_drain();

        // Input churn after accept must not disturb the latched operands
        issue(5, -1, 32'hFFFF_FFFB, 1, 0);
        for (int i = 0; i < 8; i++) begin
            b_in  = 16'($urandom);
            prod1 = $urandom;
            prod2 = $urandom;
            prod3 = $urandom;
            prod4 = $urandom;
            @(posedge clk); #1;
        end
        wait_drain();

        repeat (12) @(posedge clk);
        #1;
        chk(q.size() == 0 && qa.size() == 0, "scoreboard_empty", 32'(q.size() + qa.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
